// File: rtl/lsu_axi_wr_ctrl.sv
// lsu_axi_wr_ctrl
// AXI4 write-channel slave that sequences LSU stores into a small bank of
// user-area output registers (GPIO data, GPIO output enable, LA output word).
// Transactions are handled one at a time: AW -> W beats -> B.
//
// Ports:
//   clk, rst_l            core clock, asynchronous active-low reset
//   aw*                   write address channel (awvalid/awready/awid/awaddr/awlen)
//   w*                    write data channel (wvalid/wready/wdata/wstrb/wlast)
//   b*                    write response channel (bvalid/bready/bresp/bid)
//   gpio_out              GPIO output data register
//   gpio_oeb              inverted GPIO output-enable register (1 = input)
//   la_out                logic-analyser output register
//   wr_cnt                committed OKAY write counter (only with LSU_WR_CNT_EN)
//
// Optional feature macro: LSU_WR_CNT_EN adds the wr_cnt port and counter.
//
// Register map (offset from BASE_ADDR, bits [4:0]):
//   0x00 GPIO_OUT, 0x08 GPIO_OE, 0x10 LA_OUT; awaddr[2] selects the
//   upper 32-bit lane of the 64-bit data bus.

module lsu_axi_wr_ctrl #(
    parameter int                ID_W      = 3,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'hD000_0000,
    parameter int                IO_BITS   = 28
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                wvalid,
    output logic                wready,
    input  logic [63:0]         wdata,
    input  logic [7:0]          wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    output logic [ID_W-1:0]     bid,
    output logic [IO_BITS-1:0]  gpio_out,
    output logic [IO_BITS-1:0]  gpio_oeb,
    output logic [31:0]         la_out
`ifdef LSU_WR_CNT_EN
    ,
    output logic [15:0]         wr_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q;
    logic [ADDR_W-1:2]   addr_q;
    logic                len_nz_q;
    logic                first_q;
    logic [1:0]          bresp_q;
    logic [ID_W-1:0]     bid_q;
    logic [IO_BITS-1:0]  gpio_q;
    logic [IO_BITS-1:0]  oe_q;
    logic [31:0]         la_q;

    logic                aw_hs;
    logic                w_hs;
    logic                mapped;
    logic                commit;
    logic [31:0]         sel_data;
    logic [3:0]          sel_strb;
    logic [31:0]         gpio_ext, oe_ext;
    logic [31:0]         gpio_new, oe_new, la_new;

    // Byte address bits [1:0] carry no meaning on a 64-bit lane-select bus.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^awaddr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

    assign aw_hs = awvalid && (state_q == IDLE);
    assign w_hs  = wvalid && (state_q == DATA);

    // Decode and commit qualification use the address captured at AW time.
    assign mapped = (addr_q[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]) && (addr_q[4:3] != 2'b11);
    assign commit = w_hs && first_q && !len_nz_q && mapped;

    // Lane select and byte merge against the current register contents.
    always_comb begin
        sel_data = addr_q[2] ? wdata[63:32] : wdata[31:0];
        sel_strb = addr_q[2] ? wstrb[7:4]   : wstrb[3:0];
        gpio_ext = '0;
        oe_ext   = '0;
        gpio_ext[IO_BITS-1:0] = gpio_q;
        oe_ext[IO_BITS-1:0]   = oe_q;
        gpio_new = merge_bytes(gpio_ext, sel_data, sel_strb);
        oe_new   = merge_bytes(oe_ext, sel_data, sel_strb);
        la_new   = merge_bytes(la_q, sel_data, sel_strb);
    end

    // State register plus the captured AW fields and registered B fields.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            len_nz_q <= 1'b0;
            first_q  <= 1'b0;
            bresp_q  <= 2'b00;
            bid_q    <= '0;
        end else begin
            state_q <= state_d;
            if (aw_hs) begin
                id_q     <= awid;
                addr_q   <= awaddr[ADDR_W-1:2];
                len_nz_q <= (awlen != 8'd0);
                first_q  <= 1'b1;
            end
            if (w_hs) begin
                first_q <= 1'b0;
                if (wlast) begin
                    bresp_q <= (len_nz_q || !mapped) ? 2'b10 : 2'b00;
                    bid_q   <= id_q;
                end
            end
        end
    end

    // Next-state logic: bursts are drained until wlast before responding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (awvalid)          state_d = DATA;
            DATA:    if (wvalid && wlast)  state_d = RESP;
            RESP:    if (bready)           state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure functions of the registered state.
    always_comb begin
        awready = (state_q == IDLE);
        wready  = (state_q == DATA);
        bvalid  = (state_q == RESP);
    end

    assign bresp = bresp_q;
    assign bid   = bid_q;

    // Output register bank; OE is stored true-sense and inverted on output.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            gpio_q <= '0;
            oe_q   <= '0;
            la_q   <= '0;
        end else if (commit) begin
            case (addr_q[4:3])
                2'b00:   gpio_q <= gpio_new[IO_BITS-1:0];
                2'b01:   oe_q   <= oe_new[IO_BITS-1:0];
                2'b10:   la_q   <= la_new;
                default: ;
            endcase
        end
    end

    assign gpio_out = gpio_q;
    assign gpio_oeb = ~oe_q;
    assign la_out   = la_q;

`ifdef LSU_WR_CNT_EN
    // Zero-strobe commits leave the registers untouched, so they are not counted.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_cnt <= '0;
        end else if (commit && (sel_strb != 4'd0) && (wr_cnt != 16'hFFFF)) begin
            wr_cnt <= wr_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_axi_wr_ctrl.sv
// tb_lsu_axi_wr_ctrl
// Directed bench for lsu_axi_wr_ctrl. Expected responses are queued when a
// transaction is driven and popped when the B channel handshakes.

module tb_lsu_axi_wr_ctrl;

    logic        clk;
    logic        rst_l;
    logic        awvalid;
    logic        awready;
    logic [2:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [2:0]  bid;
    logic [27:0] gpio_out;
    logic [27:0] gpio_oeb;
    logic [31:0] la_out;
`ifdef LSU_WR_CNT_EN
    logic [15:0] wr_cnt;
`endif

    typedef struct {
        logic [1:0] resp;
        logic [2:0] id;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   beatsTaken;

    lsu_axi_wr_ctrl dut (
        .clk      (clk),
        .rst_l    (rst_l),
        .awvalid  (awvalid),
        .awready  (awready),
        .awid     (awid),
        .awaddr   (awaddr),
        .awlen    (awlen),
        .wvalid   (wvalid),
        .wready   (wready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wlast    (wlast),
        .bvalid   (bvalid),
        .bready   (bready),
        .bresp    (bresp),
        .bid      (bid),
        .gpio_out (gpio_out),
        .gpio_oeb (gpio_oeb),
        .la_out   (la_out)
`ifdef LSU_WR_CNT_EN
        ,
        .wr_cnt   (wr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One AW, then nBeats W beats; first beat uses d0/s0, later beats d1/s1.
    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] id,
                                 input logic [7:0] len, input int nBeats,
                                 input logic [63:0] d0, input logic [7:0] s0,
                                 input logic [63:0] d1, input logic [7:0] s1,
                                 input logic [1:0] expResp);
        exp_t e;
        int   c;
        e.resp = expResp;
        e.id   = id;
        sb.push_back(e);
        awvalid = 1'b1;
        awaddr  = addr;
        awid    = id;
        awlen   = len;
        c = 0;
        while (!awready && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        if (!awready) checkOutput("aw_timeout", {63'd0, awready}, 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        beatsTaken = 0;
        for (int b = 0; b < nBeats; b++) begin
            wvalid = 1'b1;
            wdata  = (b == 0) ? d0 : d1;
            wstrb  = (b == 0) ? s0 : s1;
            wlast  = (b == nBeats - 1);
            c = 0;
            while (!wready && c < 20) begin
                @(posedge clk); #1;
                c++;
            end
            if (!wready) checkOutput("w_timeout", {63'd0, wready}, 64'd1);
            else beatsTaken++;
            @(posedge clk); #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        checkOutput("bvalid_after_last", {63'd0, bvalid}, 64'd1);
        checkOutput("wready_after_last", {63'd0, wready}, 64'd0);
    endtask

    task automatic collectResponse();
        exp_t e;
        int   c;
        bready = 1'b1;
        c = 0;
        while (!bvalid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        checkOutput("b_wait", {63'd0, bvalid}, 64'd1);
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            checkOutput("bresp", {62'd0, bresp}, {62'd0, e.resp});
            checkOutput("bid", {61'd0, bid}, {61'd0, e.id});
        end
        @(posedge clk); #1;
        bready = 1'b0;
        checkOutput("bvalid_one_cycle", {63'd0, bvalid}, 64'd0);
        checkOutput("awready_back", {63'd0, awready}, 64'd1);
    endtask

    initial begin
        rst_l   = 1'b0;
        awvalid = 1'b0;
        awid    = '0;
        awaddr  = '0;
        awlen   = '0;
        wvalid  = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wlast   = 1'b0;
        bready  = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_gpio_out", {36'd0, gpio_out}, 64'd0);
        checkOutput("rst_gpio_oeb", {36'd0, gpio_oeb}, 64'hFFF_FFFF);
        checkOutput("rst_la_out", {32'd0, la_out}, 64'd0);
        checkOutput("rst_awready", {63'd0, awready}, 64'd1);
        checkOutput("rst_wready", {63'd0, wready}, 64'd0);
        checkOutput("rst_bvalid", {63'd0, bvalid}, 64'd0);
        checkOutput("rst_bresp", {62'd0, bresp}, 64'd0);
        checkOutput("rst_bid", {61'd0, bid}, 64'd0);
        rst_l = 1'b1;
        @(posedge clk); #1;

        // wvalid in IDLE is ignored
        wvalid = 1'b1;
        wdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        wstrb  = 8'hFF;
        wlast  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("idle_wready", {63'd0, wready}, 64'd0);
        checkOutput("idle_gpio", {36'd0, gpio_out}, 64'd0);
        wvalid = 1'b0;
        wlast  = 1'b0;

        // LA write, lower lane
        applyStimulus(32'hD000_0010, 3'd5, 8'd0, 1, 64'h0000_0000_CAFE_F00D, 8'h0F,
                      64'd0, 8'h00, 2'b00);
        checkOutput("la_write", {32'd0, la_out}, 64'hCAFE_F00D);
        collectResponse();

        // GPIO_OUT upper lane, bytes 0-1; lower-lane data must be ignored
        applyStimulus(32'hD000_0004, 3'd2, 8'd0, 1, 64'h0ABC_DEF1_1234_5678, 8'h30,
                      64'd0, 8'h00, 2'b00);
        checkOutput("gpio_upper_lane", {36'd0, gpio_out}, 64'h000_DEF1);
        collectResponse();

        // Unmapped offset 3
        applyStimulus(32'hD000_0018, 3'd1, 8'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
                      64'd0, 8'h00, 2'b10);
        collectResponse();
        checkOutput("off3_gpio", {36'd0, gpio_out}, 64'h000_DEF1);
        checkOutput("off3_oeb", {36'd0, gpio_oeb}, 64'hFFF_FFFF);
        checkOutput("off3_la", {32'd0, la_out}, 64'hCAFE_F00D);

        // Base mismatch
        applyStimulus(32'hE000_0000, 3'd6, 8'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
                      64'd0, 8'h00, 2'b10);
        collectResponse();
        checkOutput("base_gpio", {36'd0, gpio_out}, 64'h000_DEF1);

        // Burst of 4 beats is drained and rejected
        applyStimulus(32'hD000_0000, 3'd4, 8'd3, 4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF,
                      64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 2'b10);
        checkOutput("burst_beats", beatsTaken, 64'd4);
        collectResponse();
        checkOutput("burst_gpio", {36'd0, gpio_out}, 64'h000_DEF1);

        // Zero selected strobes: OKAY, no change
        applyStimulus(32'hD000_0010, 3'd3, 8'd0, 1, 64'h1111_1111_2222_2222, 8'hF0,
                      64'd0, 8'h00, 2'b00);
        collectResponse();
        checkOutput("zero_strb_la", {32'd0, la_out}, 64'hCAFE_F00D);

        // len=0 with extra beats: only the first beat commits
        applyStimulus(32'hD000_0000, 3'd3, 8'd0, 2, 64'h0000_0000_0000_0055, 8'h01,
                      64'h0000_0000_0000_00AA, 8'h01, 2'b00);
        checkOutput("extra_beat_gpio", {36'd0, gpio_out}, 64'h000_DE55);
        collectResponse();

        // GPIO_OE byte 0, then hold the response with bready low
        applyStimulus(32'hD000_0008, 3'd7, 8'd0, 1, 64'h0000_0000_0000_00FF, 8'h01,
                      64'd0, 8'h00, 2'b00);
        checkOutput("oe_write", {36'd0, gpio_oeb}, 64'hFFF_FF00);
`ifdef LSU_WR_CNT_EN
        checkOutput("wr_cnt", {48'd0, wr_cnt}, 64'd4);
`endif
        awvalid = 1'b1;
        awaddr  = 32'hD000_0010;
        awid    = 3'd2;
        awlen   = 8'd0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checkOutput("hold_bvalid", {63'd0, bvalid}, 64'd1);
            checkOutput("hold_bid", {61'd0, bid}, 64'd7);
            checkOutput("hold_bresp", {62'd0, bresp}, 64'd0);
            checkOutput("hold_awready", {63'd0, awready}, 64'd0);
        end
        void'(sb.pop_front());

        // Asynchronous reset while in RESP
        #2;
        rst_l   = 1'b0;
        awvalid = 1'b0;
        #1;
        checkOutput("async_bvalid", {63'd0, bvalid}, 64'd0);
        checkOutput("async_gpio", {36'd0, gpio_out}, 64'd0);
        checkOutput("async_oeb", {36'd0, gpio_oeb}, 64'hFFF_FFFF);
        checkOutput("async_la", {32'd0, la_out}, 64'd0);
`ifdef LSU_WR_CNT_EN
        checkOutput("async_wr_cnt", {48'd0, wr_cnt}, 64'd0);
`endif
        @(posedge clk); #1;
        rst_l = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_awready", {63'd0, awready}, 64'd1);
        checkOutput("post_rst_bvalid", {63'd0, bvalid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
